// File: rtl/decode_exec_pkg.sv
// ============================================================================
//  decode_exec_pkg -- opcode/funct constants and ALU operation encoding
//  Revision: 1.0
// ============================================================================
`default_nettype none

package decode_exec_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/dx_alu.sv
// ============================================================================
//  dx_alu -- combinational integer ALU for the decode/execute pipe
//  Revision: 1.0
// ============================================================================
`default_nettype none

module dx_alu
    import decode_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_SLL:    y = a << shamt;
            ALU_SLT:    y = XLEN'($signed(a) < $signed(b));
            ALU_SLTU:   y = XLEN'(a < b);
            ALU_XOR:    y = a ^ b;
            ALU_SRL:    y = a >> shamt;
            ALU_SRA:    y = $unsigned($signed(a) >>> shamt);
            ALU_OR:     y = a | b;
            ALU_AND:    y = a & b;
            ALU_PASS_B: y = b;
            default:    y = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/decode_exec_pipe.sv
// ============================================================================
//  decode_exec_pipe -- two-stage RV-subset decode/execute pipe with regfile
//  Revision: 1.0
// ============================================================================
`default_nettype none

module decode_exec_pipe
    import decode_exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instruction,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            mem_rd,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] regwrdata,
    output logic            regwr,
    output logic            illegal
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef struct packed {
        alu_op_e         op;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            load;
        logic            illegal;
        logic            regwr;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
    } s1_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            regwr;
        logic            illegal;
        logic            load;
    } s2_t;

    logic            s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    s1_t             s1_q, s1_d, dec;
    s2_t             s2_q, s2_d;
    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];

    logic [6:0]      opcode, funct7, sh_f;
    logic [2:0]      funct3;
    logic [4:0]      rd_f, rs1_f, rs2_f;
    logic [XLEN-1:0] imm_i, imm_u;
    logic            use_rs1, use_rs2, uses_rd, bad_f;
    logic            commit, s1_move, accept;
    logic [XLEN-1:0] op_a, op_b, alu_b, alu_y;

    assign opcode = instruction[6:0];
    assign rd_f   = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1_f  = instruction[19:15];
    assign rs2_f  = instruction[24:20];
    assign funct7 = instruction[31:25];
    // RV64 shifts carry a 6-bit shamt, so only imm[11:6] acts as the funct field
    assign sh_f   = (XLEN == 64) ? {instruction[31:26], 1'b0} : instruction[31:25];
    assign imm_i  = XLEN'($signed(instruction[31:20]));
    assign imm_u  = XLEN'($signed({instruction[31:12], 12'b0}));

    function automatic logic idx_bad(input logic [4:0] idx);
        return (NREG < 32) && (int'(idx) >= NREG);
    endfunction

    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        uses_rd = 1'b0;
        bad_f   = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                use_rs1     = 1'b1;
                uses_rd     = 1'b1;
                dec.use_imm = 1'b1;
                dec.imm     = imm_i;
                case (funct3)
                    F3_ADD:  dec.op = ALU_ADD;
                    F3_SLT:  dec.op = ALU_SLT;
                    F3_SLTU: dec.op = ALU_SLTU;
                    F3_XOR:  dec.op = ALU_XOR;
                    F3_OR:   dec.op = ALU_OR;
                    F3_AND:  dec.op = ALU_AND;
                    F3_SLL: begin
                        dec.op = ALU_SLL;
                        bad_f  = (sh_f != F7_BASE);
                    end
                    F3_SRL: begin
                        dec.op = (sh_f == F7_ALT) ? ALU_SRA : ALU_SRL;
                        bad_f  = (sh_f != F7_BASE) && (sh_f != F7_ALT);
                    end
                    default: bad_f = 1'b1;
                endcase
            end
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                uses_rd = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, F3_ADD}:  dec.op = ALU_ADD;
                    {F7_ALT,  F3_ADD}:  dec.op = ALU_SUB;
                    {F7_BASE, F3_SLL}:  dec.op = ALU_SLL;
                    {F7_BASE, F3_SLT}:  dec.op = ALU_SLT;
                    {F7_BASE, F3_SLTU}: dec.op = ALU_SLTU;
                    {F7_BASE, F3_XOR}:  dec.op = ALU_XOR;
                    {F7_BASE, F3_SRL}:  dec.op = ALU_SRL;
                    {F7_ALT,  F3_SRL}:  dec.op = ALU_SRA;
                    {F7_BASE, F3_OR}:   dec.op = ALU_OR;
                    {F7_BASE, F3_AND}:  dec.op = ALU_AND;
                    default:            bad_f  = 1'b1;
                endcase
            end
            OPC_LUI: begin
                uses_rd     = 1'b1;
                dec.op      = ALU_PASS_B;
                dec.use_imm = 1'b1;
                dec.imm     = imm_u;
            end
            OPC_LOAD: begin
                use_rs1     = 1'b1;
                uses_rd     = 1'b1;
                dec.op      = ALU_ADD;
                dec.use_imm = 1'b1;
                dec.imm     = imm_i;
                dec.load    = 1'b1;
                bad_f       = (funct3 != F3_LW);
            end
            default: bad_f = 1'b1;
        endcase
        dec.illegal = bad_f || (use_rs1 && idx_bad(rs1_f)) || (use_rs2 && idx_bad(rs2_f))
                    || (uses_rd && idx_bad(rd_f));
        dec.load    = dec.load && !dec.illegal;
        dec.regwr   = !dec.illegal && (rd_f != 5'd0);
        dec.rd      = rd_f;
        dec.rs1     = rs1_f;
        dec.rs2     = rs2_f;
    end

    assign commit   = s2_valid_q && out_ready;
    assign s1_move  = s1_valid_q && (!s2_valid_q || commit);
    assign in_ready = !rst && (!s1_valid_q || s1_move);
    assign accept   = in_valid && in_ready;

    assign out_valid = s2_valid_q;
    assign regwr     = s2_valid_q && s2_q.regwr;
    assign illegal   = s2_valid_q && s2_q.illegal;
    assign mem_rd    = s2_valid_q && s2_q.load;
    assign mem_addr  = mem_rd ? s2_q.result : '0;
    assign rd_addr   = s2_valid_q ? s2_q.rd : 5'd0;
    assign regwrdata = !s2_valid_q ? '0 : (s2_q.load ? data : s2_q.result);

    // Same-edge commit bypasses the regfile so back-to-back dependents see it
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (s1_q.rs1 != 5'd0) op_a = rf_q[s1_q.rs1[IW-1:0]];
        if (s1_q.rs2 != 5'd0) op_b = rf_q[s1_q.rs2[IW-1:0]];
        if (commit && regwr && (rd_addr == s1_q.rs1)) op_a = regwrdata;
        if (commit && regwr && (rd_addr == s1_q.rs2)) op_b = regwrdata;
    end

    assign alu_b = s1_q.use_imm ? s1_q.imm : op_b;

    dx_alu #(.XLEN(XLEN)) u_alu (
        .op (s1_q.op),
        .a  (op_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_d       = dec;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (s1_move) begin
            s2_valid_d   = 1'b1;
            s2_d.result  = alu_y;
            s2_d.rd      = s1_q.rd;
            s2_d.regwr   = s1_q.regwr;
            s2_d.illegal = s1_q.illegal;
            s2_d.load    = s1_q.load;
        end else if (commit) begin
            s2_valid_d = 1'b0;
        end

        rf_d = rf_q;
        if (commit && regwr) rf_d[rd_addr[IW-1:0]] = regwrdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            rf_q       <= '{default: '0};
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            rf_q       <= rf_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/decode_exec_pipe.md
DECODE_EXEC_PIPE -- requirements
Module: decode_exec_pipe

Interface
REQ-001 The block SHALL have the parameter XLEN, default 32, giving the datapath width (32 or 64).
REQ-002 The block SHALL have the parameter NREG, default 32, giving the register count (16 or 32).
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have the ports instruction (input, 32 bits), in_valid (input, 1 bit) and in_ready (output, 1 bit): the instruction-accept handshake.
REQ-006 The block SHALL have the ports mem_rd (output, 1 bit), mem_addr (output, XLEN bits) and data (input, XLEN bits): the load request and its same-cycle load data.
REQ-007 The block SHALL have the ports out_valid (output, 1 bit) and out_ready (input, 1 bit): the result handshake.
REQ-008 The block SHALL have the ports rd_addr (output, 5 bits), regwrdata (output, XLEN bits), regwr (output, 1 bit) and illegal (output, 1 bit): the committed result.

Function
REQ-009 The block SHALL form a two-stage pipeline: S1 (decoded fields) and S2 (operands and result), each with its own valid bit.
REQ-010 An instruction SHALL be accepted into S1 on an edge where in_valid && in_ready.
REQ-011 S1 SHALL move to S2 on an edge where S1 is valid and (S2 is empty or S2 commits).
REQ-012 in_ready SHALL equal !S1_valid || S1 moves this cycle.
REQ-013 A commit SHALL occur on an edge where out_valid && out_ready.
REQ-014 out_valid SHALL equal S2_valid.
REQ-015 With no stall, out_valid SHALL assert after the second edge following acceptance, giving 2-cycle latency and a throughput of 1 per cycle.
REQ-016 Register operands SHALL be read on the S1->S2 edge.
REQ-017 If an S2 commit writes the register being read on that same edge, the read SHALL return the committing value (bypass).
REQ-018 The decoded subset SHALL be: OP-IMM (0010011) ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI; OP (0110011) ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; LUI (0110111); LOAD (0000011) with funct3=010 (LW).
REQ-019 Immediates SHALL be sign-extended to XLEN.
REQ-020 LUI SHALL produce imm[31:12]<<12, sign-extended to XLEN.
REQ-021 Shift amounts SHALL use the low log2(XLEN) bits of the shift operand.
REQ-022 SLT SHALL compare signed, SLTU SHALL compare unsigned, and both SHALL produce a result of 0 or 1.
REQ-023 Arithmetic SHALL wrap modulo 2^XLEN with no overflow flag.
REQ-024 For LW, mem_rd SHALL be 1 while S2 holds the load, mem_addr SHALL be rs1+imm, and regwrdata SHALL be data as sampled at commit; at all other times mem_rd SHALL be 0.
REQ-025 An unsupported opcode or funct, or an rs1/rs2/rd index >= NREG, SHALL still flow through the pipeline with illegal=1 and regwr=0, and SHALL leave no register modified.
REQ-026 The register file SHALL be written with regwrdata at rd on a commit with regwr=1.
REQ-027 rd=0 SHALL force regwr=0.
REQ-028 x0 SHALL always read as 0.
REQ-029 While out_valid=1 && out_ready=0, rd_addr, regwrdata, regwr, illegal and mem_addr SHALL hold stable, and no instruction SHALL be lost or duplicated.
REQ-030 rd_addr, regwrdata, regwr and illegal SHALL be 0 whenever out_valid=0.

Reset
REQ-031 Asserting rst SHALL immediately clear S1_valid and S2_valid, forcing out_valid=0, mem_rd=0, regwr=0 and illegal=0, independent of clk.
REQ-032 Reset SHALL clear all registers to 0.
REQ-033 in_ready SHALL be 0 while rst is asserted.
REQ-034 in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-035 An instruction in flight at reset SHALL be discarded without committing.

Structure
REQ-036 The package decode_exec_pkg SHALL hold the opcode constants, the funct3/funct7 constants and the ALU-operation enum.
REQ-037 A combinational sub-module dx_alu (XLEN-parametrised; inputs op, a, b; output y) SHALL perform all ALU arithmetic.
REQ-038 The register file SHALL reside inside decode_exec_pipe.

Verification
REQ-039 A bench SHALL cover: reset, then ADDI x2,x0,5 (0x00500113) -> 2 cycles later out_valid=1, rd_addr=2, regwrdata=5, regwr=1.
REQ-040 A bench SHALL cover: back-to-back ADDI x1,x0,-1 then ADD x3,x1,x1 -> second result 0xFFFFFFFE (bypass).
REQ-041 A bench SHALL cover: out_ready=0 for 4 cycles while 3 instructions are offered -> in_ready=0 after 2 accepts, outputs stable; after release all 3 commit in order.
REQ-042 A bench SHALL cover: x1=0x80000000, SRAI x4,x1,31 -> 0xFFFFFFFF; SLTU x5,x0,x1 -> 1; with XLEN=64, SLLI x6,x1,63 -> 0.
REQ-043 A bench SHALL cover: LW x7,8(x1) with x1=0x100 and data=0xDEADBEEF -> mem_rd=1, mem_addr=0x108, regwrdata=0xDEADBEEF; then instruction 0x0000007F -> illegal=1, regwr=0, and an ADDI x0,x0,1 leaves x0=0.
REQ-044 A bench SHALL cover: rst pulsed mid-stall with S2 full -> out_valid falls before the next edge, the in-flight result never commits, and a subsequent read of x2 returns 0.
